// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyphs and drive polarities
// for common-anode displays.
package seg7_pkg;

  localparam logic AN_ON  = 1'b0;
  localparam logic AN_OFF = 1'b1;
  localparam logic DP_ON  = 1'b0;
  localparam logic DP_OFF = 1'b1;

  // Bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Single-digit BCD to active-low seven-segment decoder; non-decimal codes
// show a dash so corrupted counter values are visible on the display.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed common-anode display driver: scans shadowed BCD digits
// onto a shared segment bus with leading-zero blanking and anti-ghost window.
module bcd_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        r_divCnt;
  logic [IDX_W-1:0]        r_digIdx;
  logic [4*NUM_DIGITS-1:0] r_bcdShadow;
  logic [NUM_DIGITS-1:0]   r_dpShadow;

  logic                  w_slotEnd;
  logic                  w_capture;
  logic [3:0]            w_curBcd;
  logic [6:0]            w_glyph;
  logic [NUM_DIGITS-1:0] w_zeroAbove;
  logic                  w_blanked;
  logic [NUM_DIGITS-1:0] w_anNext;

  assign w_slotEnd = (r_divCnt == DIV_LAST);
  assign w_capture = w_slotEnd && (r_digIdx == IDX_LAST);
  assign w_curBcd  = r_bcdShadow[{r_digIdx, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .i_bcd (w_curBcd),
    .o_seg (w_glyph)
  );

  // Shadow capture on the last cycle of the last slot keeps each frame coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divCnt    <= '0;
      r_digIdx    <= '0;
      r_bcdShadow <= '0;
      r_dpShadow  <= '0;
    end else begin
      if (w_slotEnd) begin
        r_divCnt <= '0;
        r_digIdx <= (r_digIdx == IDX_LAST) ? '0 : r_digIdx + IDX_W'(1);
      end else begin
        r_divCnt <= r_divCnt + DIV_W'(1);
      end
      if (w_capture) begin
        r_bcdShadow <= bcd_in;
        r_dpShadow  <= dp_in;
      end
    end
  end

  // Bit k is set when shadow digits k..top are all zero; invalid codes are non-zero.
  always_comb begin
    logic run;
    run         = 1'b1;
    w_zeroAbove = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run            = run && (r_bcdShadow[4*k +: 4] == 4'd0);
      w_zeroAbove[k] = run;
    end
  end

  assign w_blanked = blank_lz && (r_digIdx != '0) && w_zeroAbove[r_digIdx];

  always_comb begin
    w_anNext = {NUM_DIGITS{AN_OFF}};
    if (r_divCnt >= BLANK_END) begin
      w_anNext[r_digIdx] = AN_ON;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= {NUM_DIGITS{AN_OFF}};
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      frame_tick <= 1'b0;
    end else begin
      an         <= w_anNext;
      seg        <= w_blanked ? SEG_OFF : w_glyph;
      dp         <= (!w_blanked && r_dpShadow[r_digIdx]) ? DP_ON : DP_OFF;
      frame_tick <= w_capture;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: each frame's expected slots are queued
// when stimulus is issued and checked by a monitor as each digit lights.
module tb_bcd_scan_display;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int    nCompared   = 0;
  int    nMismatched = 0;
  slot_t expQ[$];

  logic [15:0] pendBcd;
  logic [3:0]  pendDp;
  logic        pendLz;

  bcd_scan_display #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Hand-written glyph table, independent of the design package.
  function automatic logic [6:0] tbGlyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic int topNonZero(input logic [15:0] v);
    int top = 0;
    for (int k = 0; k < 4; k++) if (v[4*k +: 4] != 4'd0) top = k;
    return top;
  endfunction

  task automatic pushFrame(input logic [15:0] v, input logic [3:0] dpv, input logic lz);
    slot_t s;
    int    top;
    top = topNonZero(v);
    for (int k = 0; k < 4; k++) begin
      s.an = ~(4'b0001 << k);
      if (lz && k > top) begin
        s.seg = 7'h7F;
        s.dp  = 1'b1;
      end else begin
        s.seg = tbGlyph(v[4*k +: 4]);
        s.dp  = ~dpv[k];
      end
      expQ.push_back(s);
    end
  endtask

  task automatic waitTick(output int cycles);
    cycles = 0;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_tick) begin
        cycles = c;
        break;
      end
    end
  endtask

  // Called on the negedge where frame_tick is seen: the pending vector is now
  // being displayed, and the new one is driven for capture at this frame's end.
  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] dpv,
                               input logic lz, input logic [15:0] early);
    int gap = 0;
    blank_lz = pendLz;
    pushFrame(pendBcd, pendDp, pendLz);
    bcd_in = early;
    dp_in  = dpv;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 8) bcd_in = v;
      if (frame_tick) begin
        gap = c;
        break;
      end
    end
    checkOutput("frameGap", gap, 16);
    pendBcd = v;
    pendDp  = dpv;
    pendLz  = lz;
  endtask

  // Monitor: pops one expected slot each time a digit lights, checks every lit
  // cycle, and checks the 1-cycle blank / 3-cycle lit slot shape.
  initial begin
    int    litRun    = 0;
    int    blankRun  = 0;
    logic  curValid  = 1'b0;
    slot_t cur;
    forever begin
      @(negedge clk);
      if (rst) begin
        litRun   = 0;
        blankRun = 0;
        curValid = 1'b0;
      end else if (an == 4'hF) begin
        if (litRun != 0) checkOutput("litRun", litRun, 3);
        litRun = 0;
        blankRun++;
      end else begin
        if (litRun == 0) begin
          checkOutput("blankRun", blankRun, 1);
          blankRun = 0;
          checkOutput("slotExpected", (expQ.size() > 0) ? 1 : 0, 1);
          curValid = (expQ.size() > 0);
          if (curValid) cur = expQ.pop_front();
        end
        litRun++;
        if (curValid) begin
          checkOutput("slotAn", an, cur.an);
          checkOutput("slotSeg", seg, cur.seg);
          checkOutput("slotDp", dp, cur.dp);
        end
      end
    end
  end

  initial begin
    int   cycles;
    logic found;
    rst      = 1'b1;
    bcd_in   = 16'h1234;
    dp_in    = 4'h0;
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetAn", an, 4'hF);
    checkOutput("resetSeg", seg, 7'h7F);
    checkOutput("resetDp", dp, 1'b1);
    checkOutput("resetTick", frame_tick, 1'b0);

    pushFrame(16'h0000, 4'h0, 1'b0);
    pendBcd = 16'h1234;
    pendDp  = 4'h0;
    pendLz  = 1'b0;
    #1 rst = 1'b0;
    waitTick(cycles);
    checkOutput("firstTickLatency", cycles, 16);

    applyStimulus(16'h0070, 4'b1000, 1'b1, 16'h0070);
    applyStimulus(16'h0070, 4'b1000, 1'b0, 16'h0070);
    applyStimulus(16'h0000, 4'b0000, 1'b1, 16'h0000);
    applyStimulus(16'h00A5, 4'b0000, 1'b1, 16'h00A5);
    applyStimulus(16'h1111, 4'b0000, 1'b0, 16'h1111);
    applyStimulus(16'h2222, 4'b0000, 1'b0, 16'h1111);
    applyStimulus(16'h8090, 4'b0100, 1'b1, 16'h8090);

    blank_lz = pendLz;
    pushFrame(pendBcd, pendDp, pendLz);
    waitTick(cycles);
    checkOutput("frameGap", cycles, 16);
    checkOutput("queueDrained", expQ.size(), 0);

    // Reset in the middle of digit 1 of a recaptured frame.
    pushFrame(pendBcd, pendDp, pendLz);
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an == 4'b1101) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("sawDigit1", found, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midResetAn", an, 4'hF);
    checkOutput("midResetSeg", seg, 7'h7F);
    checkOutput("midResetDp", dp, 1'b1);
    expQ.delete();
    pushFrame(16'h0000, 4'h0, blank_lz);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    waitTick(cycles);
    checkOutput("postResetTick", cycles, 16);
    checkOutput("postResetDrained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
